cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Front-end controller that shares one cache_system_* instance (direct, 2-way or 4-way; identical port set) among NUM_REQ requesters.
- Round-robin arbitration, sequences the single-cycle `read` strobe, waits a fixed response latency, and returns data and L1/L2 hit flags to the granted requester.
- Keeps aggregate L1 hit/miss statistics, replacing the bench-side counting done today.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 11, address width; matches the cache_system addr port.
- DATA_W, 32, read data width.
- RESP_LAT, 1, cycles from the cache_read-high cycle to the cycle in which cache outputs are sampled; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until accepted.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- resp_data  out  DATA_W  read data; valid while any resp_valid is high.
- resp_l1_hit  out  1  L1 hit flag for the response.
- resp_l2_hit  out  1  L2 hit flag for the response.
- cache_addr  out  ADDR_W  to cache_system addr.
- cache_read  out  1  to cache_system read.
- cache_read_data  in  DATA_W  from cache_system read_data.
- cache_l1_hit  in  1  from cache_system l1_hit.
- cache_l2_hit  in  1  from cache_system l2_hit.
- clear_stats  in  1  synchronous clear of the statistics counters.
- l1_hit_count  out  32  saturating L1 hit count.
- l1_miss_count  out  32  saturating L1 miss count.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; every output = 0, including cache_addr and both counters.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts it: no resp_valid is issued and the request is dropped. The requester must re-present it.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
  - IDLE: if any req_valid, choose g = first set bit scanning from last_grant+1 (mod NUM_REQ). Same cycle: req_ready[g]=1; register cache_addr <= req_addr[g] and grant index g. Next state ISSUE. If no req_valid, stay in IDLE.
  - ISSUE: cache_read=1 for exactly this one cycle; load wait counter with RESP_LAT-1. Next state WAIT.
  - WAIT: cache_read=0. When the counter is 0, register cache_read_data, cache_l1_hit and cache_l2_hit, then go to RESP. Otherwise decrement the counter.
  - RESP: resp_valid[g]=1 with the registered data and flags; update counters; last_grant <= g. Next state IDLE.
- Timing:
  - Latency, accept to response: RESP_LAT+2 cycles. Accept at T, cache_read at T+1, sample at T+1+RESP_LAT, resp_valid at T+2+RESP_LAT.
  - One transaction in flight; throughput is one per RESP_LAT+3 cycles.
- Holding rules:
  - cache_addr holds its last value outside transactions.
  - resp_data and resp flags hold their last values after RESP.
  - req_valid/req_addr changes while not granted are ignored. No other requester is accepted while busy.
- Counters:
  - In RESP, cache_l1_hit sampled 1 -> l1_hit_count+1, else l1_miss_count+1.
  - Both counters saturate at 32'hFFFF_FFFF.
  - clear_stats zeroes both and wins over a same-cycle increment.
- Simultaneous requests: round-robin, strictly fair; a requester held valid is served within NUM_REQ transactions.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W=11, DATA_W=32.
  - State enum {IDLE, ISSUE, WAIT, RESP}.
  - Saturating-increment function.
- One sub-module: rr_arbiter (NUM_REQ). Combinational one-hot grant from req_valid and last_grant; the pointer is updated by the parent.

Test Plan:
- Single requester, RESP_LAT=1, addr 0x123 twice on cache_system_direct: responses at T+3. First response resp_l1_hit=0, second resp_l1_hit=1. Counters hit=1, miss=1.
- NUM_REQ=4, all req_valid held after reset: grant order 0,1,2,3,0. Each req_ready pulse is 4 cycles apart, one-hot.
- Reset asserted while in WAIT: next cycle busy=0 and all outputs 0. No resp_valid is ever issued for the aborted request.
- clear_stats asserted in the same cycle as RESP with an L1 hit: both counters read 0 the next cycle.
- Counter preloaded to 32'hFFFF_FFFF via force, then another hit: value stays 32'hFFFF_FFFF.
- RESP_LAT=3, 100 random addresses against a scoreboard model: resp_data matches the cache model each time. Latency is always 5 cycles.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache request front-end.
package cache_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Requester-side request/response bundle of the cache front-end.
interface cache_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W  = cache_pkg::DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_l1_hit;
  logic                      resp_l2_hit;

  // Requesters drive requests and consume accepts/responses.
  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_l1_hit, resp_l2_hit
  );

  // The arbiter consumes requests and produces accepts/responses.
  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_l1_hit, resp_l2_hit
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant; the caller owns and updates last_grant.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Scan from last_grant+1 upward with wrap; first set request wins.
  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant) + i) % NUM_REQ;
      sel = IDX_W'(idx);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache_system instance among NUM_REQ requesters: round-robin
// accept, one-cycle read strobe, fixed-latency sample, response return and
// saturating L1 hit/miss statistics.
module cache_req_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W   = cache_pkg::DATA_W,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  cache_req_arbiter_if.slave  req_if,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic                cache_read,
  input  logic [DATA_W-1:0]   cache_read_data,
  input  logic                cache_l1_hit,
  input  logic                cache_l2_hit,
  input  logic                clear_stats,
  output logic [31:0]         l1_hit_count,
  output logic [31:0]         l1_miss_count,
  output logic                busy
);

  import cache_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;
  logic [2:0]         wait_cnt;
  logic [DATA_W-1:0]  data_q;
  logic               l1_q;
  logic               l2_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [31:0]        hit_cnt;
  logic [31:0]        miss_cnt;
  logic [ADDR_W-1:0]  sel_addr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_if.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (any_req)
  );

  // Accept must coincide with the IDLE cycle that sees the request, so it is
  // the only output not taken straight from a register.
  assign req_if.req_ready = (state == IDLE) ? grant : '0;
  assign sel_addr         = req_if.req_addr[grant_idx*ADDR_W +: ADDR_W];

  assign req_if.resp_valid  = resp_valid_q;
  assign req_if.resp_data   = data_q;
  assign req_if.resp_l1_hit = l1_q;
  assign req_if.resp_l2_hit = l2_q;
  assign l1_hit_count       = hit_cnt;
  assign l1_miss_count      = miss_cnt;
  assign busy               = (state != IDLE);

  // Transaction sequencer, response registers and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      cur_idx      <= '0;
      cache_addr   <= '0;
      cache_read   <= 1'b0;
      wait_cnt     <= '0;
      data_q       <= '0;
      l1_q         <= 1'b0;
      l2_q         <= 1'b0;
      resp_valid_q <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      cache_read   <= 1'b0;
      resp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cache_addr <= sel_addr;
            cur_idx    <= grant_idx;
            cache_read <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 3'(RESP_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            data_q       <= cache_read_data;
            l1_q         <= cache_l1_hit;
            l2_q         <= cache_l2_hit;
            resp_valid_q <= NUM_REQ'(1) << cur_idx;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          last_grant <= cur_idx;
          if (l1_q) hit_cnt  <= sat_inc(hit_cnt);
          else      miss_cnt <= sat_inc(miss_cnt);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (clear_stats) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: two instances (4 requesters / latency 1 and
// 2 requesters / latency 3) each fronting a behavioural direct-mapped cache.
module tb_cache_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  cache_req_arbiter_if #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(32)) ifa ();
  cache_req_arbiter_if #(.NUM_REQ(2), .ADDR_W(11), .DATA_W(32)) ifb ();

  logic [10:0] a_caddr, b_caddr;
  logic        a_crd, b_crd;
  logic [31:0] a_cdata, b_cdata;
  logic        a_cl1, a_cl2, b_cl1, b_cl2;
  logic [31:0] a_hits, a_miss, b_hits, b_miss;
  logic        a_busy, b_busy;

  cache_req_arbiter #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(32), .RESP_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_if(ifa),
    .cache_addr(a_caddr), .cache_read(a_crd), .cache_read_data(a_cdata),
    .cache_l1_hit(a_cl1), .cache_l2_hit(a_cl2), .clear_stats(clr),
    .l1_hit_count(a_hits), .l1_miss_count(a_miss), .busy(a_busy)
  );

  cache_req_arbiter #(.NUM_REQ(2), .ADDR_W(11), .DATA_W(32), .RESP_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req_if(ifb),
    .cache_addr(b_caddr), .cache_read(b_crd), .cache_read_data(b_cdata),
    .cache_l1_hit(b_cl1), .cache_l2_hit(b_cl2), .clear_stats(clr),
    .l1_hit_count(b_hits), .l1_miss_count(b_miss), .busy(b_busy)
  );

  // ---------------- behavioural cache stand-ins ----------------
  typedef struct packed {
    logic [31:0] d;
    logic        l1;
    logic        l2;
  } cresp_t;

  logic [6:0] ctag  [2][16];
  bit         cvld  [2][16];
  bit         cseen [2][2048];
  cresp_t     a_pipe;
  cresp_t     b_pipe [3];

  function automatic logic [31:0] data_of(input logic [10:0] a);
    return ({21'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic cresp_t cache_access(input int inst, input logic [10:0] a);
    cresp_t r;
    r.d  = data_of(a);
    r.l1 = cvld[inst][a[3:0]] && (ctag[inst][a[3:0]] == a[10:4]);
    r.l2 = !r.l1 && cseen[inst][a];
    cvld[inst][a[3:0]] = 1'b1;
    ctag[inst][a[3:0]] = a[10:4];
    cseen[inst][a]     = 1'b1;
    return r;
  endfunction

  function automatic cresp_t junk();
    cresp_t r;
    r.d  = $urandom;
    r.l1 = 1'($urandom);
    r.l2 = 1'($urandom);
    return r;
  endfunction

  // Outputs are only meaningful exactly RESP_LAT cycles after the read; junk otherwise.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 16; j++) cvld[i][j] = 1'b0;
        for (int j = 0; j < 2048; j++) cseen[i][j] = 1'b0;
      end
    end
    a_pipe    <= a_crd ? cache_access(0, a_caddr) : junk();
    b_pipe[0] <= b_crd ? cache_access(1, b_caddr) : junk();
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  assign a_cdata = a_pipe.d;
  assign a_cl1   = a_pipe.l1;
  assign a_cl2   = a_pipe.l2;
  assign b_cdata = b_pipe[2].d;
  assign b_cl1   = b_pipe[2].l1;
  assign b_cl2   = b_pipe[2].l2;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rdy(input int inst);
    return (inst == 0) ? ifa.req_ready : {2'b00, ifb.req_ready};
  endfunction

  function automatic logic [3:0] rvl(input int inst);
    return (inst == 0) ? ifa.resp_valid : {2'b00, ifb.resp_valid};
  endfunction

  task automatic set_req(input int inst, input int k, input logic v, input logic [10:0] addr);
    if (inst == 0) begin
      ifa.req_valid[k] = v;
      ifa.req_addr[k*11 +: 11] = addr;
    end else begin
      ifb.req_valid[k] = v;
      ifb.req_addr[k*11 +: 11] = addr;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic txn(input int inst, input int k, input logic [10:0] addr,
                     output int lat, output logic [31:0] d, output logic l1,
                     output logic l2, output logic [3:0] rv);
    int         t_acc, t_resp;
    bit         got;
    logic [3:0] r;
    lat = -1; d = '0; l1 = 1'b0; l2 = 1'b0; rv = '0;
    t_acc = 0; t_resp = 0; got = 1'b0;
    set_req(inst, k, 1'b1, addr);
    for (int i = 0; i < 30; i++) begin
      #1;
      r = rdy(inst);
      if (r[k]) begin
        got   = 1'b1;
        t_acc = cyc;
        check("accept_onehot", 32'(r), 32'(1) << k);
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", 32'(got), 32'd1);
    @(negedge clk);
    set_req(inst, k, 1'b0, 11'($urandom));
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rvl(inst) != 4'd0) begin
        got    = 1'b1;
        t_resp = cyc;
        rv     = rvl(inst);
        d      = (inst == 0) ? ifa.resp_data   : ifb.resp_data;
        l1     = (inst == 0) ? ifa.resp_l1_hit : ifb.resp_l1_hit;
        l2     = (inst == 0) ? ifa.resp_l2_hit : ifb.resp_l2_hit;
        break;
      end
      @(negedge clk);
    end
    check("resp_seen", 32'(got), 32'd1);
    lat = t_resp - t_acc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          lat, n, idx, t_prev, exp_hits, k;
    logic [31:0] d;
    logic        l1, l2, seen, exp_l1;
    logic [3:0]  rv, r;
    logic [10:0] addr;
    logic [10:0] last_at [16];
    bit          has_at  [16];

    ifa.req_valid = '0; ifa.req_addr = '0;
    ifb.req_valid = '0; ifb.req_addr = '0;
    do_reset();

    // Reset state
    check("rst_ready",    32'(ifa.req_ready),  32'd0);
    check("rst_resp_v",   32'(ifa.resp_valid), 32'd0);
    check("rst_data",     ifa.resp_data,       32'd0);
    check("rst_l1",       32'(ifa.resp_l1_hit), 32'd0);
    check("rst_l2",       32'(ifa.resp_l2_hit), 32'd0);
    check("rst_caddr",    32'(a_caddr),        32'd0);
    check("rst_cread",    32'(a_crd),          32'd0);
    check("rst_hits",     a_hits,              32'd0);
    check("rst_miss",     a_miss,              32'd0);
    check("rst_busy",     32'(a_busy),         32'd0);
    check("rst_busy_b",   32'(b_busy),         32'd0);

    // Single requester, same address twice, then conflict and L2 refill
    txn(0, 0, 11'h123, lat, d, l1, l2, rv);
    check("t1a_lat", lat, 32'd3);
    check("t1a_data", d, data_of(11'h123));
    check("t1a_l1", 32'(l1), 32'd0);
    check("t1a_l2", 32'(l2), 32'd0);
    check("t1a_rv", 32'(rv), 32'd1);
    txn(0, 0, 11'h123, lat, d, l1, l2, rv);
    check("t1b_lat", lat, 32'd3);
    check("t1b_l1", 32'(l1), 32'd1);
    @(negedge clk);
    check("t1_hits", a_hits, 32'd1);
    check("t1_miss", a_miss, 32'd1);
    check("t1_data_hold", ifa.resp_data, data_of(11'h123));
    check("t1_caddr_hold", 32'(a_caddr), 32'h123);
    txn(0, 0, 11'h133, lat, d, l1, l2, rv);
    check("t1c_l1", 32'(l1), 32'd0);
    txn(0, 0, 11'h123, lat, d, l1, l2, rv);
    check("t1d_l1", 32'(l1), 32'd0);
    check("t1d_l2", 32'(l2), 32'd1);

    // Four requesters held valid from reset: grants 0,1,2,3,0, four cycles apart
    do_reset();
    for (int j = 0; j < 4; j++) set_req(0, j, 1'b1, 11'(32'h100 + j));
    n = 0; t_prev = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      #1;
      r = rdy(0);
      if (r != 4'd0) begin
        check("rr_onehot", $countones(r), 32'd1);
        idx = 0;
        for (int j = 0; j < 4; j++) if (r[j]) idx = j;
        check("rr_order", idx, n % 4);
        if (n > 0) check("rr_spacing", cyc - t_prev, 32'd4);
        t_prev = cyc;
        n++;
      end
      @(negedge clk);
    end
    check("rr_count", n, 32'd5);
    for (int j = 0; j < 4; j++) set_req(0, j, 1'b0, 11'd0);
    for (int i = 0; i < 20 && a_busy; i++) @(negedge clk);

    // Reset while waiting on the cache aborts the transaction
    set_req(1, 0, 1'b1, 11'h055);
    #1;
    check("abort_accept", 32'(rdy(1)), 32'd1);
    @(negedge clk);
    set_req(1, 0, 1'b0, 11'd0);
    @(negedge clk);
    check("abort_busy_wait", 32'(b_busy), 32'd1);
    check("abort_cread_wait", 32'(b_crd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(b_busy), 32'd0);
    check("abort_ready", 32'(ifb.req_ready), 32'd0);
    check("abort_resp_v", 32'(ifb.resp_valid), 32'd0);
    check("abort_data", ifb.resp_data, 32'd0);
    check("abort_l1", 32'(ifb.resp_l1_hit), 32'd0);
    check("abort_l2", 32'(ifb.resp_l2_hit), 32'd0);
    check("abort_caddr", 32'(b_caddr), 32'd0);
    check("abort_cread", 32'(b_crd), 32'd0);
    check("abort_hits", b_hits, 32'd0);
    check("abort_miss", b_miss, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ifb.resp_valid != 2'b00) seen = 1'b1;
    end
    check("abort_no_resp", 32'(seen), 32'd0);

    // clear_stats in the RESP cycle of a hit wins over the increment
    txn(0, 1, 11'h2A0, lat, d, l1, l2, rv);
    check("clr_first_l1", 32'(l1), 32'd0);
    check("clr_first_rv", 32'(rv), 32'd2);
    @(negedge clk);
    check("clr_pre_miss", a_miss, 32'd1);
    txn(0, 1, 11'h2A0, lat, d, l1, l2, rv);
    check("clr_second_l1", 32'(l1), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_hits", a_hits, 32'd0);
    check("clr_miss", a_miss, 32'd0);

    // Saturation of the hit counter
    force dut_a.hit_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_a.hit_cnt;
    txn(0, 2, 11'h2A0, lat, d, l1, l2, rv);
    check("sat_l1", 32'(l1), 32'd1);
    @(negedge clk);
    check("sat_hits", a_hits, 32'hFFFF_FFFF);
    check("sat_miss", a_miss, 32'd0);

    // Random addresses on the latency-3 instance against the reference model
    exp_hits = 0;
    for (int j = 0; j < 16; j++) begin
      has_at[j]  = 1'b0;
      last_at[j] = '0;
    end
    for (int i = 0; i < 100; i++) begin
      k    = int'($urandom_range(0, 1));
      addr = 11'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_l1 = has_at[addr[3:0]] && (last_at[addr[3:0]] == addr);
      has_at[addr[3:0]]  = 1'b1;
      last_at[addr[3:0]] = addr;
      if (exp_l1) exp_hits++;
      txn(1, k, addr, lat, d, l1, l2, rv);
      check("rnd_lat", lat, 32'd5);
      check("rnd_data", d, data_of(addr));
      check("rnd_rv", 32'(rv), 32'(1) << k);
      check("rnd_l1", 32'(l1), 32'(exp_l1));
    end
    @(negedge clk);
    check("rnd_hits", b_hits, 32'(exp_hits));
    check("rnd_miss", b_miss, 32'(100 - exp_hits));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
